// File: rtl/fir_sample_feeder.sv
// Sample buffer in front of the FIR: converts signed PCM to float32 on write, then streams
// the block through the FIR's reset/next/stop handshake and zero-pads while it drains.
module fir_sample_feeder #(
   parameter int DEPTH        = 256,
   parameter int PCM_W        = 16,
   parameter int DRAIN_PULSES = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [PCM_W-1:0]          wr_data,
   output logic                      wr_full,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      fir_rst,
   output logic [31:0]               fir_in,
   input  logic                      fir_next,
   output logic                      fir_stop
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DRAIN_PULSES + 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [DW-1:0] DRAIN_LAST_C = DW'(DRAIN_PULSES - 1);

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_PRIME  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   // Normalise an unsigned magnitude into float32; every PCM_W <= 24 value is exact.
   function automatic logic [31:0] pcm_to_f32(input logic sgn, input logic [PCM_W-1:0] mag);
      logic [4:0]  msb;
      logic [23:0] aligned;
      msb = 5'd0;
      for (int i = 0; i < PCM_W; i++) begin
         if (mag[i]) begin
            msb = 5'(i);
         end
      end
      aligned = 24'(mag) << (5'd23 - msb);
      if (mag == {PCM_W{1'b0}}) begin
         return 32'h0000_0000;
      end else begin
         return {sgn, 8'd127 + {3'd0, msb}, aligned[22:0]};
      end
   endfunction

   state_t            state_r;
   logic              start_pend_r;
   logic [AW-1:0]     idx_r;
   logic [DW-1:0]     drain_cnt_r;
   logic [AW:0]       count_r;
   logic              full_r;
   logic              done_r;
   logic              fir_rst_r;
   logic [31:0]       fir_in_r;
   logic              fir_stop_r;
   logic              v1_r;
   logic              sign1_r;
   logic [PCM_W-1:0]  mag1_r;
   logic [31:0]       mem_r [DEPTH];

   logic              accept_s;
   logic [AW-1:0]     idx_inc_s;
   logic [AW:0]       idx_ext_s;

   // A write is taken only while loading, before start is latched, and if it cannot overflow.
   assign accept_s  = wr_en && (state_r == ST_LOAD) && !start_pend_r &&
                      ((count_r + {{AW{1'b0}}, v1_r}) < DEPTH_C);
   assign idx_inc_s = idx_r + AW'(1);
   assign idx_ext_s = {1'b0, idx_r} + (AW+1)'(1);

   // Stage 1: split the sample into sign and magnitude; the most negative code stays exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r    <= 1'b0;
         sign1_r <= 1'b0;
         mag1_r  <= {PCM_W{1'b0}};
      end else begin
         v1_r <= accept_s;
         if (accept_s) begin
            sign1_r <= wr_data[PCM_W-1];
            mag1_r  <= wr_data[PCM_W-1] ? (~wr_data + PCM_W'(1)) : wr_data;
         end
      end
   end

   // Stage 2: normalise and store at the next free slot.
   always_ff @(posedge clk) begin
      if (v1_r) begin
         mem_r[count_r[AW-1:0]] <= pcm_to_f32(sign1_r, mag1_r);
      end
   end

   // Control FSM with the sample counter and all FIR-facing registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_LOAD;
         start_pend_r <= 1'b0;
         idx_r        <= {AW{1'b0}};
         drain_cnt_r  <= {DW{1'b0}};
         count_r      <= {(AW+1){1'b0}};
         full_r       <= 1'b0;
         done_r       <= 1'b0;
         fir_rst_r    <= 1'b1;
         fir_in_r     <= 32'h0000_0000;
         fir_stop_r   <= 1'b0;
      end else begin
         if (v1_r) begin
            count_r <= count_r + (AW+1)'(1);
            full_r  <= ((count_r + (AW+1)'(1)) == DEPTH_C);
         end
         case (state_r)
            ST_LOAD: begin
               fir_rst_r <= 1'b1;
               // Leave only once the in-flight sample has landed so it joins the block.
               if (start_pend_r && !v1_r) begin
                  start_pend_r <= 1'b0;
                  if (count_r == {(AW+1){1'b0}}) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r  <= ST_PRIME;
                     idx_r    <= {AW{1'b0}};
                     fir_in_r <= mem_r[{AW{1'b0}}];
                  end
               end else if (start) begin
                  start_pend_r <= 1'b1;
               end
            end
            ST_PRIME: begin
               state_r   <= ST_SETTLE;
               fir_rst_r <= 1'b0;
            end
            ST_SETTLE: begin
               state_r <= ST_RUN;
            end
            ST_RUN: begin
               if (fir_next) begin
                  if (idx_ext_s < count_r) begin
                     idx_r    <= idx_inc_s;
                     fir_in_r <= mem_r[idx_inc_s];
                  end else begin
                     fir_in_r    <= 32'h0000_0000;
                     fir_stop_r  <= 1'b1;
                     drain_cnt_r <= {DW{1'b0}};
                     state_r     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (fir_next) begin
                  if (drain_cnt_r == DRAIN_LAST_C) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     drain_cnt_r <= drain_cnt_r + DW'(1);
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_r    <= ST_LOAD;
                  count_r    <= {(AW+1){1'b0}};
                  full_r     <= 1'b0;
                  done_r     <= 1'b0;
                  fir_rst_r  <= 1'b1;
                  fir_stop_r <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_LOAD;
               fir_rst_r <= 1'b1;
            end
         endcase
      end
   end

   assign busy     = v1_r || start_pend_r ||
                     (state_r == ST_PRIME) || (state_r == ST_SETTLE) ||
                     (state_r == ST_RUN)   || (state_r == ST_DRAIN);
   assign wr_full  = full_r;
   assign done     = done_r;
   assign count    = count_r;
   assign fir_rst  = fir_rst_r;
   assign fir_in   = fir_in_r;
   assign fir_stop = fir_stop_r;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: conversion, streaming handshake, drain, full buffer,
// empty block, mid-stream reset and late start.
module tb_fir_sample_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_full;
   logic        start;
   logic        busy;
   logic        done;
   logic [8:0]  count;
   logic        fir_rst;
   logic [31:0] fir_in;
   logic        fir_next;
   logic        fir_stop;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [0:7];

   fir_sample_feeder #(.DEPTH(256), .PCM_W(16), .DRAIN_PULSES(7)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .start(start), .busy(busy), .done(done), .count(count), .fir_rst(fir_rst),
      .fir_in(fir_in), .fir_next(fir_next), .fir_stop(fir_stop)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [15:0] v, input logic with_start);
      wr_en   = 1'b1;
      wr_data = v;
      start   = with_start;
      tick();
      wr_en   = 1'b0;
      start   = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic restart();
      go();
      check("restart_done",  32'(done),    32'd0);
      check("restart_count", 32'(count),   32'd0);
      check("restart_rst",   32'(fir_rst), 32'd1);
   endtask

   // Stream n samples answering with fir_next every gap cycles, then the drain pulses.
   task automatic run_block(input int n, input int gap);
      int w;
      w = 0;
      while (fir_rst !== 1'b0 && w < 64) begin
         tick();
         w++;
      end
      check("fir_rst_release", 32'(fir_rst), 32'd0);
      check("block_count", 32'(count), 32'(n));
      check("first_in", fir_in, exp_q[0]);
      for (int k = 0; k < n; k++) begin
         repeat (gap - 1) tick();
         fir_next = 1'b1;
         tick();
         fir_next = 1'b0;
         if (k + 1 < n) begin
            check("next_in", fir_in, exp_q[k+1]);
            check("stop_low", 32'(fir_stop), 32'd0);
         end else begin
            check("tail_zero", fir_in, 32'd0);
            check("stop_rise", 32'(fir_stop), 32'd1);
         end
      end
      for (int d = 0; d < 7; d++) begin
         repeat (gap - 1) tick();
         fir_next = 1'b1;
         tick();
         fir_next = 1'b0;
         check("drain_done", 32'(done), (d == 6) ? 32'd1 : 32'd0);
      end
      check("done_busy", 32'(busy), 32'd0);
      check("done_fir_rst", 32'(fir_rst), 32'd0);
      check("done_stop", 32'(fir_stop), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w;
      rst = 1'b1; wr_en = 1'b0; wr_data = 16'd0; start = 1'b0; fir_next = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_full",  32'(wr_full),  32'd0);
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_done",  32'(done),     32'd0);
      check("rst_count", 32'(count),    32'd0);
      check("rst_firrst",32'(fir_rst),  32'd1);
      check("rst_firin", fir_in,        32'd0);
      check("rst_stop",  32'(fir_stop), 32'd0);

      // Conversion corners
      put(16'h0000, 1'b0); put(16'h0001, 1'b0); put(16'hFFFF, 1'b0);
      put(16'h7FFF, 1'b0); put(16'h8000, 1'b0);
      tick(); tick();
      check("conv_count", 32'(count), 32'd5);
      exp_q[0] = 32'h0000_0000; exp_q[1] = 32'h3F80_0000; exp_q[2] = 32'hBF80_0000;
      exp_q[3] = 32'h46FF_FE00; exp_q[4] = 32'hC700_0000;
      go();
      run_block(5, 8);
      restart();

      // {1,2,3} with start in the same cycle as the last write
      put(16'd1, 1'b0); put(16'd2, 1'b0); put(16'd3, 1'b1);
      exp_q[0] = 32'h3F80_0000; exp_q[1] = 32'h4000_0000; exp_q[2] = 32'h4040_0000;
      run_block(3, 8);
      restart();

      // Single sample: first pulse goes straight to drain
      put(16'hFFFF, 1'b0);
      tick(); tick();
      exp_q[0] = 32'hBF80_0000;
      go();
      run_block(1, 2);
      restart();

      // Start one cycle after the last write
      put(16'd5, 1'b0); put(16'd6, 1'b0);
      go();
      exp_q[0] = 32'h40A0_0000; exp_q[1] = 32'h40C0_0000;
      run_block(2, 3);
      restart();

      // Empty block
      go();
      check("empty_rst0", 32'(fir_rst), 32'd1);
      tick();
      check("empty_done", 32'(done), 32'd1);
      check("empty_rst1", 32'(fir_rst), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      check("empty_rst2", 32'(fir_rst), 32'd1);
      restart();

      // Full buffer
      for (int i = 0; i < 257; i++) put(16'(i), 1'b0);
      repeat (3) tick();
      check("full_count", 32'(count), 32'd256);
      check("full_flag", 32'(wr_full), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("full_clr_count", 32'(count), 32'd0);
      check("full_clr_flag", 32'(wr_full), 32'd0);

      // Reset during RUN
      put(16'd7, 1'b0); put(16'd8, 1'b0);
      tick(); tick();
      go();
      w = 0;
      while (fir_rst !== 1'b0 && w < 64) begin
         tick();
         w++;
      end
      check("mid_release", 32'(fir_rst), 32'd0);
      tick(); tick();
      check("mid_busy_run", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_firrst", 32'(fir_rst), 32'd1);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_count", 32'(count), 32'd0);
      check("mid_stop", 32'(fir_stop), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
